// File: rtl/zigzag_runlevel.sv
// zigzag_runlevel: reorders a latched 4x4 coefficient block into zigzag order and
// streams (level, run, last) pairs over a valid/ready handshake.
module zigzag_runlevel #(
   parameter int BIT_LENGTH = 15
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [16*(BIT_LENGTH+1)-1:0] coeffs,
   input  logic                         start,
   output logic                         in_ready,
   output logic signed [BIT_LENGTH:0]   level,
   output logic [3:0]                   run,
   output logic                         last,
   output logic                         pair_valid,
   input  logic                         pair_ready,
   output logic [4:0]                   totalcoeff,
   output logic                         done
);
   localparam int W = BIT_LENGTH + 1;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] EMIT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;
   // raster index of each zigzag position, position 0 in the low nibble
   localparam logic [63:0] ZZ = {4'd15, 4'd14, 4'd11, 4'd7, 4'd10, 4'd13, 4'd12, 4'd9,
                                 4'd6, 4'd3, 4'd2, 4'd5, 4'd8, 4'd4, 4'd1, 4'd0};

   logic [1:0]         state_q, state_d;
   logic [15:0][W-1:0] buf_q, buf_d;
   logic [3:0]         idx_q, idx_d, run_q, run_d, prun_q, prun_d;
   logic [4:0]         cnt_q, cnt_d, tc_q, tc_d;
   logic [W-1:0]       level_q, level_d, cur;
   logic               last_q, last_d;
   logic [15:0]        nz;

   always_comb begin
      for (int i = 0; i < 16; i++) nz[i] = |buf_q[i];
      state_d = state_q;
      buf_d   = buf_q;
      idx_d   = idx_q;
      run_d   = run_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      prun_d  = prun_q;
      last_d  = last_q;
      tc_d    = tc_q;
      cur     = buf_q[idx_q];
      if (enable) begin
         case (state_q)
            IDLE: if (start) begin
               // the buffer is stored already reordered, so SCAN walks it linearly
               for (int i = 0; i < 16; i++) buf_d[i] = coeffs[W*int'(ZZ[4*i +: 4]) +: W];
               idx_d   = '0;
               run_d   = '0;
               cnt_d   = '0;
               state_d = SCAN;
            end
            SCAN: if (cur == '0) begin
               run_d   = run_q + 4'd1;
               idx_d   = idx_q + 4'd1;
               state_d = (idx_q == 4'd15) ? DONE : SCAN;
               tc_d    = (idx_q == 4'd15) ? cnt_q : tc_q;
            end else begin
               level_d = cur;
               prun_d  = run_q;
               last_d  = ~|((nz >> idx_q) >> 1);
               cnt_d   = cnt_q + 5'd1;
               state_d = EMIT;
            end
            EMIT: if (pair_ready) begin
               state_d = last_q ? DONE : SCAN;
               tc_d    = last_q ? cnt_q : tc_q;
               idx_d   = idx_q + 4'd1;
               run_d   = '0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         buf_q   <= '0;
         idx_q   <= '0;
         run_q   <= '0;
         cnt_q   <= '0;
         level_q <= '0;
         prun_q  <= '0;
         last_q  <= 1'b0;
         tc_q    <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         idx_q   <= idx_d;
         run_q   <= run_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         prun_q  <= prun_d;
         last_q  <= last_d;
         tc_q    <= tc_d;
      end
   end

   assign in_ready   = state_q == IDLE;
   assign pair_valid = state_q == EMIT;
   assign done       = state_q == DONE;
   assign level      = level_q;
   assign run        = prun_q;
   assign last       = last_q;
   assign totalcoeff = tc_q;
endmodule

// File: tb/tb_zigzag_runlevel.sv
// tb_zigzag_runlevel: table-driven vectors plus hand-written backpressure, enable,
// busy-start and mid-block reset sequences for zigzag_runlevel.
module tb_zigzag_runlevel;
   logic               clk = 1'b0, reset = 1'b0, enable = 1'b1, start = 1'b0, pair_ready = 1'b1;
   logic [255:0]       coeffs = '0;
   logic               in_ready, last, pair_valid, done;
   logic signed [15:0] level;
   logic [3:0]         run;
   logic [4:0]         totalcoeff;
   int                 passed = 0, total = 0;

   typedef struct {
      logic signed [15:0] c [16];
      int                 n;
      logic signed [15:0] lv [16];
      logic [3:0]         rn [16];
      int                 t_first;
      int                 tc;
   } vec_t;
   vec_t vecs [5];

   zigzag_runlevel #(.BIT_LENGTH(15)) dut (
      .clk(clk), .reset(reset), .enable(enable), .coeffs(coeffs), .start(start),
      .in_ready(in_ready), .level(level), .run(run), .last(last), .pair_valid(pair_valid),
      .pair_ready(pair_ready), .totalcoeff(totalcoeff), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic load(input int v);
      for (int j = 0; j < 16; j++) coeffs[16*j +: 16] = vecs[v].c[j];
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      coeffs = {8{$urandom()}};
   endtask

   task automatic wait_valid(input string nm);
      for (int k = 0; k < 40 && !pair_valid; k++) @(negedge clk);
      chk(nm, 32'(pair_valid), 1);
   endtask

   task automatic run_block(input int v);
      int t, p, first;
      logic dn;
      t = 0; p = 0; first = -1; dn = 1'b0;
      load(v);
      pulse_start();
      while (!dn && t < 100) begin
         @(posedge clk);
         t++;
         @(negedge clk);
         if (pair_valid) begin
            if (first < 0) first = t;
            if (p < 16) begin
               chk($sformatf("v%0d_level%0d", v, p), 32'(level), 32'(vecs[v].lv[p]));
               chk($sformatf("v%0d_run%0d", v, p), 32'(run), 32'(vecs[v].rn[p]));
               chk($sformatf("v%0d_last%0d", v, p), 32'(last), 32'(p == vecs[v].n - 1));
            end
            p++;
         end
         if (done) begin
            dn = 1'b1;
            chk($sformatf("v%0d_totalcoeff", v), 32'(totalcoeff), 32'(vecs[v].tc));
            if (vecs[v].n == 0) chk($sformatf("v%0d_done_time", v), t, vecs[v].t_first);
         end
      end
      chk($sformatf("v%0d_done_seen", v), 32'(dn), 1);
      chk($sformatf("v%0d_pair_count", v), p, vecs[v].n);
      if (vecs[v].n > 0) chk($sformatf("v%0d_first_time", v), first, vecs[v].t_first);
      @(negedge clk);
      chk($sformatf("v%0d_in_ready_after", v), 32'(in_ready), 1);
      chk($sformatf("v%0d_done_1cyc", v), 32'(done), 0);
   endtask

   initial begin
      automatic logic signed [15:0] l3 [16] = '{1,2,5,9,6,3,4,7,10,13,14,11,8,12,15,16};
      for (int v = 0; v < 5; v++)
         for (int j = 0; j < 16; j++) begin
            vecs[v].c[j] = 0; vecs[v].lv[j] = 0; vecs[v].rn[j] = 0;
         end
      vecs[0].n = 0; vecs[0].t_first = 16; vecs[0].tc = 0;
      vecs[1].c[0] = 5; vecs[1].c[15] = -3; vecs[1].n = 2; vecs[1].t_first = 1; vecs[1].tc = 2;
      vecs[1].lv[0] = 5; vecs[1].lv[1] = -3; vecs[1].rn[1] = 14;
      vecs[2].c[4] = 7; vecs[2].n = 1; vecs[2].lv[0] = 7; vecs[2].rn[0] = 2;
      vecs[2].t_first = 3; vecs[2].tc = 1;
      for (int j = 0; j < 16; j++) begin
         vecs[3].c[j] = 16'(j + 1); vecs[3].lv[j] = l3[j];
      end
      vecs[3].n = 16; vecs[3].t_first = 1; vecs[3].tc = 16;
      vecs[4].c[1] = -2; vecs[4].c[6] = 3; vecs[4].c[12] = 4; vecs[4].n = 3;
      vecs[4].lv[0] = -2; vecs[4].lv[1] = 3; vecs[4].lv[2] = 4;
      vecs[4].rn[0] = 1; vecs[4].rn[1] = 5; vecs[4].rn[2] = 1;
      vecs[4].t_first = 2; vecs[4].tc = 3;

      #12;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_pair_valid", 32'(pair_valid), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_run", 32'(run), 0);
      chk("rst_last", 32'(last), 0);
      chk("rst_totalcoeff", 32'(totalcoeff), 0);
      chk("rst_done", 32'(done), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 5; v++) run_block(v);

      // backpressure with a start pulse while busy
      load(1);
      pair_ready = 1'b0;
      pulse_start();
      wait_valid("bp_first_valid");
      start = 1'b1;
      coeffs = {16{16'd9}};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("bp_hold_valid%0d", k), 32'(pair_valid), 1);
         chk($sformatf("bp_hold_level%0d", k), 32'(level), 5);
         chk($sformatf("bp_hold_run%0d", k), 32'(run), 0);
         chk($sformatf("bp_hold_last%0d", k), 32'(last), 0);
      end
      start = 1'b0;
      pair_ready = 1'b1;
      @(negedge clk);
      pair_ready = 1'b0;
      chk("bp_after_hs_valid", 32'(pair_valid), 0);
      wait_valid("bp_second_valid");
      @(negedge clk);
      chk("bp_second_level", 32'(level), 32'(-16'sd3));
      chk("bp_second_run", 32'(run), 14);
      chk("bp_second_last", 32'(last), 1);
      pair_ready = 1'b1;
      @(negedge clk);
      chk("bp_done", 32'(done), 1);
      chk("bp_totalcoeff", 32'(totalcoeff), 2);
      repeat (4) @(negedge clk);
      chk("bp_no_queued_start", 32'(pair_valid), 0);
      chk("bp_idle", 32'(in_ready), 1);

      // enable dropped for 3 cycles after the first SCAN edge
      load(2);
      pulse_start();
      @(posedge clk);
      #1 enable = 1'b0;
      repeat (3) @(posedge clk);
      #1 enable = 1'b1;
      @(negedge clk);
      chk("en_t4_valid", 32'(pair_valid), 0);
      @(negedge clk);
      chk("en_t5_valid", 32'(pair_valid), 0);
      @(negedge clk);
      chk("en_t6_valid", 32'(pair_valid), 1);
      chk("en_level", 32'(level), 7);
      chk("en_run", 32'(run), 2);
      chk("en_last", 32'(last), 1);
      @(negedge clk);
      chk("en_done", 32'(done), 1);
      chk("en_totalcoeff", 32'(totalcoeff), 1);
      @(negedge clk);

      // asynchronous reset while a pair is stalled in EMIT
      load(3);
      pair_ready = 1'b0;
      pulse_start();
      wait_valid("rstmid_valid");
      chk("rstmid_level_before", 32'(level), 1);
      #2 reset = 1'b0;
      #1;
      chk("rstmid_pair_valid", 32'(pair_valid), 0);
      chk("rstmid_level", 32'(level), 0);
      chk("rstmid_run", 32'(run), 0);
      chk("rstmid_last", 32'(last), 0);
      chk("rstmid_done", 32'(done), 0);
      chk("rstmid_totalcoeff", 32'(totalcoeff), 0);
      chk("rstmid_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      reset = 1'b1;
      pair_ready = 1'b1;
      @(negedge clk);
      run_block(4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
